placar_hex: RTL and testbench
=============================

// Module: placar_hex
// PURPOSE
//  Score and lives keeper for the game, driving the six seven-segment digits (HEX5..HEX0).
//  Sits downstream of the entities block: it consumes that block's enemy-hit and ship-damage event lines.
//  It keeps a 4-digit BCD score and a lives counter with a post-hit invulnerability window.
//  It produces the perdeu (game over) flag that the screen block consumes.
// PARAMETERS
//  PONTOS_ACERTO   8'h10     2-digit BCD points added per enemy hit (legal range 01..99)
//  VIDAS_INICIAIS  4'd3      lives loaded at reset (1..9)
//  INVULN_CICLOS   25000000  CLOCK_50 cycles after damage during which further damage is ignored
// PORTS
//  CLOCK_50        in   1   system clock, 50 MHz
//  reset           in   1   asynchronous, active-high
//  pausa           in   1   1 = game paused; new events are discarded
//  acerto_inimigo  in   1   level from entities; a 0->1 edge = one enemy hit
//  dano_nave       in   1   level from entities; a 0->1 edge = one ship hit
//  pontos          out  16  score, 4 BCD digits, [15:12] = thousands
//  vidas           out  4   remaining lives, binary
//  invulneravel    out  1   1 while the invulnerability window runs
//  perdeu          out  1   game over; sticky until reset
//  HEX0..HEX3      out  7   score digits (HEX0 = units); segments active-low, bit0 = a .. bit6 = g
//  HEX4            out  7   blank (7'h7F); shows '-' (7'h3F) while invulneravel=1
//  HEX5            out  7   lives digit 0..9
// BEHAVIOUR
//  Reset (async, asserted):
//   - pontos=0, vidas=VIDAS_INICIAIS, invulneravel=0, perdeu=0, invulnerability counter=0.
//   - Both edge-detect registers reset to 1, so a line held high across reset release is not an event.
//  Edge detect:
//   - ev_x = x & ~x_q, where x_q is the input registered every cycle, including during pausa and perdeu.
//   - An event is therefore never deferred: if it is ignored, it is lost.
//   - Inputs are already synchronous to CLOCK_50; no synchronizer is instantiated.
//  State machine (2 bits):
//   - JOGANDO: normal play.
//   - INVULN: damage window active.
//   - FIM: game over.
//  JOGANDO:
//   - ev_acerto & ~pausa -> pontos += PONTOS_ACERTO on the next edge (latency 1).
//   - The add is BCD with per-digit decimal carry.
//   - If the result would exceed 9999, pontos saturates at 16'h9999. There is no wrap.
//   - ev_dano & ~pausa -> vidas -= 1.
//     - Resulting vidas == 0: go to FIM and set perdeu=1 (same edge).
//     - Otherwise: go to INVULN, load the counter with INVULN_CICLOS-1, set invulneravel=1.
//  INVULN:
//   - Score updates exactly as in JOGANDO.
//   - ev_dano is ignored.
//   - The counter decrements each cycle only while pausa=0; it holds while paused.
//   - When the counter is 0 and pausa=0: go to JOGANDO and clear invulneravel (the window lasts exactly INVULN_CICLOS unpaused cycles).
//  FIM:
//   - All events are ignored; pontos and vidas are frozen.
//   - Only reset leaves FIM (to JOGANDO).
//  Simultaneous acerto and dano in one cycle:
//   - Both take effect on the same edge.
//   - The score is credited even if the same hit ends the game.
//  Display:
//   - The HEX outputs are registered, decoded from the registered pontos/vidas: one extra cycle behind them.
//   - Segment codes 0..9: 40,79,24,30,19,12,02,78,00,10 (hex).
//   - Digit values >9 cannot occur; the decoder defaults to blank.
//  Reset mid-operation: an immediate return to reset values, including during INVULN or FIM.
// TESTING
//  - Reset, then acerto pulses x3 with PONTOS_ACERTO=8'h10 -> pontos=16'h0030; HEX1=7'h30, HEX0=7'h40.
//  - Preload pontos to 16'h9995 via 999 hits of 8'h10 and 1 hit with PONTOS_ACERTO=8'h05 build, then one more hit of 05 -> pontos=16'h9999 (saturated).
//  - With INVULN_CICLOS=8: dano pulse -> vidas=2, invulneravel=1.
//    - Second dano 3 cycles later -> vidas stays 2.
//    - invulneravel drops exactly 8 cycles after entry.
//  - With pausa=1: acerto and dano edges -> no change.
//    - Drop pausa while the inputs are still high -> still no change (edge lost).
//  - Three spaced dano pulses (VIDAS_INICIAIS=3) -> vidas=0 and perdeu=1 on the third.
//    - A later acerto -> pontos unchanged.
//    - Then assert reset -> perdeu=0 and vidas=3 asynchronously.
//  - acerto and dano rise in the same cycle with vidas=1 -> pontos += 10, vidas=0 and perdeu=1 on the same edge.

Source files
------------

// File: rtl/placar_hex.sv
// Score and lives keeper: 4-digit BCD score, lives with a post-hit invulnerability window,
// sticky game-over flag and registered seven-segment drive for HEX5..HEX0.
module placar_hex #(
    parameter logic [7:0]  PONTOS_ACERTO  = 8'h10,
    parameter logic [3:0]  VIDAS_INICIAIS = 4'd3,
    parameter int unsigned INVULN_CICLOS  = 25000000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        pausa,
    input  logic        acerto_inimigo,
    input  logic        dano_nave,
    output logic [15:0] pontos,
    output logic [3:0]  vidas,
    output logic        invulneravel,
    output logic        perdeu,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5
);

    typedef enum logic [1:0] {
        StJogando = 2'd0,
        StInvuln  = 2'd1,
        StFim     = 2'd2
    } estado_t;

    localparam logic [15:0] Incremento = {8'h00, PONTOS_ACERTO};
    localparam logic [31:0] CntCarga   = 32'(INVULN_CICLOS - 1);
    localparam logic [6:0]  SegApagado = 7'h7F;
    localparam logic [6:0]  SegTraco   = 7'h3F;

    estado_t     estado_q, estado_d;
    logic [15:0] pontos_q, pontos_d, pontos_soma;
    logic [3:0]  vidas_q, vidas_d;
    logic [31:0] cnt_q, cnt_d;
    logic        acerto_q, dano_q;
    logic        ev_acerto, ev_dano;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = SegApagado;
        endcase
        return s;
    endfunction

    // Edge-detect registers reset high so a line held across reset release is not an event.
    assign ev_acerto = acerto_inimigo & ~acerto_q;
    assign ev_dano   = dano_nave & ~dano_q;

    // Per-digit decimal add; a carry out of the thousands digit saturates the score.
    always_comb begin
        logic [4:0] soma;
        logic       carry;
        carry       = 1'b0;
        pontos_soma = '0;
        for (int i = 0; i < 4; i++) begin
            soma = {1'b0, pontos_q[4*i +: 4]} + {1'b0, Incremento[4*i +: 4]} + {4'd0, carry};
            if (soma > 5'd9) begin
                soma  = soma - 5'd10;
                carry = 1'b1;
            end else begin
                carry = 1'b0;
            end
            pontos_soma[4*i +: 4] = soma[3:0];
        end
        if (carry) begin
            pontos_soma = 16'h9999;
        end
    end

    always_comb begin
        estado_d = estado_q;
        pontos_d = pontos_q;
        vidas_d  = vidas_q;
        cnt_d    = cnt_q;
        case (estado_q)
            StJogando: begin
                if (ev_acerto && !pausa) begin
                    pontos_d = pontos_soma;
                end
                if (ev_dano && !pausa) begin
                    vidas_d = vidas_q - 4'd1;
                    if (vidas_q == 4'd1) begin
                        estado_d = StFim;
                    end else begin
                        estado_d = StInvuln;
                        cnt_d    = CntCarga;
                    end
                end
            end
            StInvuln: begin
                if (ev_acerto && !pausa) begin
                    pontos_d = pontos_soma;
                end
                if (!pausa) begin
                    if (cnt_q == 32'd0) begin
                        estado_d = StJogando;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
            end
            StFim: begin
            end
            default: estado_d = StJogando;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            estado_q <= StJogando;
            pontos_q <= '0;
            vidas_q  <= VIDAS_INICIAIS;
            cnt_q    <= '0;
            acerto_q <= 1'b1;
            dano_q   <= 1'b1;
        end else begin
            estado_q <= estado_d;
            pontos_q <= pontos_d;
            vidas_q  <= vidas_d;
            cnt_q    <= cnt_d;
            acerto_q <= acerto_inimigo;
            dano_q   <= dano_nave;
        end
    end

    // Display registers trail the registered score/lives by one cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            HEX0 <= seg7(4'd0);
            HEX1 <= seg7(4'd0);
            HEX2 <= seg7(4'd0);
            HEX3 <= seg7(4'd0);
            HEX4 <= SegApagado;
            HEX5 <= seg7(VIDAS_INICIAIS);
        end else begin
            HEX0 <= seg7(pontos_q[3:0]);
            HEX1 <= seg7(pontos_q[7:4]);
            HEX2 <= seg7(pontos_q[11:8]);
            HEX3 <= seg7(pontos_q[15:12]);
            HEX4 <= (estado_q == StInvuln) ? SegTraco : SegApagado;
            HEX5 <= seg7(vidas_q);
        end
    end

    assign pontos       = pontos_q;
    assign vidas        = vidas_q;
    assign invulneravel = (estado_q == StInvuln);
    assign perdeu       = (estado_q == StFim);

endmodule

// File: tb/tb_placar_hex.sv
// Directed bench for placar_hex: main instance (hit 10, 3 lives, 8-cycle window) plus a
// second instance with hit 05 for the saturation-from-9995 case.
module tb_placar_hex;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pausa = 1'b0;
    logic        acerto = 1'b0;
    logic        dano = 1'b0;
    logic [15:0] pontos;
    logic [3:0]  vidas;
    logic        invulneravel, perdeu;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    logic        acerto2 = 1'b0;
    logic [15:0] pontos2;
    logic [3:0]  vidas2;
    logic        inv2, perdeu2;
    logic [6:0]  h2_0, h2_1, h2_2, h2_3, h2_4, h2_5;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    placar_hex #(
        .PONTOS_ACERTO (8'h10),
        .VIDAS_INICIAIS(4'd3),
        .INVULN_CICLOS (8)
    ) dut (
        .CLOCK_50      (clk),
        .reset         (reset),
        .pausa         (pausa),
        .acerto_inimigo(acerto),
        .dano_nave     (dano),
        .pontos        (pontos),
        .vidas         (vidas),
        .invulneravel  (invulneravel),
        .perdeu        (perdeu),
        .HEX0          (hex0),
        .HEX1          (hex1),
        .HEX2          (hex2),
        .HEX3          (hex3),
        .HEX4          (hex4),
        .HEX5          (hex5)
    );

    placar_hex #(
        .PONTOS_ACERTO (8'h05),
        .VIDAS_INICIAIS(4'd3),
        .INVULN_CICLOS (8)
    ) dut5 (
        .CLOCK_50      (clk),
        .reset         (reset),
        .pausa         (1'b0),
        .acerto_inimigo(acerto2),
        .dano_nave     (1'b0),
        .pontos        (pontos2),
        .vidas         (vidas2),
        .invulneravel  (inv2),
        .perdeu        (perdeu2),
        .HEX0          (h2_0),
        .HEX1          (h2_1),
        .HEX2          (h2_2),
        .HEX3          (h2_3),
        .HEX4          (h2_4),
        .HEX5          (h2_5)
    );

    // Stimulus helpers: each returns on the falling edge after the pulse has been clocked in.
    task automatic pulse_acerto();
        @(negedge clk) acerto = 1'b1;
        @(negedge clk) acerto = 1'b0;
    endtask

    task automatic pulse_dano();
        @(negedge clk) dano = 1'b1;
        @(negedge clk) dano = 1'b0;
    endtask

    task automatic pulse_acerto2();
        @(negedge clk) acerto2 = 1'b1;
        @(negedge clk) acerto2 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        acerto = 1'b1;
        dano   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pontos !== 16'h0000 || vidas !== 4'd3 || invulneravel !== 1'b0 || perdeu !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: pontos=%h vidas=%0d inv=%b perdeu=%b, want 0000 3 0 0",
                     pontos, vidas, invulneravel, perdeu);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (pontos !== 16'h0000 || vidas !== 4'd3) begin
            failures++;
            $display("FAIL held_line_at_release: pontos=%h vidas=%0d, want 0000 3", pontos, vidas);
        end
        checks++;
        if (hex0 !== 7'h40 || hex3 !== 7'h40 || hex4 !== 7'h7F || hex5 !== 7'h30) begin
            failures++;
            $display("FAIL reset_hex: hex0=%h hex3=%h hex4=%h hex5=%h, want 40 40 7f 30",
                     hex0, hex3, hex4, hex5);
        end
        acerto = 1'b0;
        dano   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_acerto();
        pulse_acerto();
        checks++;
        if (pontos !== 16'h0010) begin
            failures++;
            $display("FAIL acerto_latency: pontos=%h, want 0010", pontos);
        end
        pulse_acerto();
        pulse_acerto();
        checks++;
        if (pontos !== 16'h0030) begin
            failures++;
            $display("FAIL acerto_x3: pontos=%h, want 0030", pontos);
        end
        @(negedge clk);
        checks++;
        if (hex1 !== 7'h30 || hex0 !== 7'h40 || hex2 !== 7'h40 || hex3 !== 7'h40) begin
            failures++;
            $display("FAIL acerto_hex: hex3..0=%h %h %h %h, want 40 40 30 40",
                     hex3, hex2, hex1, hex0);
        end
    endtask

    task automatic test_invuln();
        pulse_dano();
        checks++;
        if (vidas !== 4'd2 || invulneravel !== 1'b1) begin
            failures++;
            $display("FAIL dano_entry: vidas=%0d inv=%b, want 2 1", vidas, invulneravel);
        end
        @(negedge clk);
        @(negedge clk) dano = 1'b1;
        @(negedge clk) dano = 1'b0;
        checks++;
        if (vidas !== 4'd2 || invulneravel !== 1'b1) begin
            failures++;
            $display("FAIL dano_ignored: vidas=%0d inv=%b, want 2 1", vidas, invulneravel);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (invulneravel !== 1'b1 || hex4 !== 7'h3F || hex5 !== 7'h24) begin
            failures++;
            $display("FAIL window_last_cycle: inv=%b hex4=%h hex5=%h, want 1 3f 24",
                     invulneravel, hex4, hex5);
        end
        @(negedge clk);
        checks++;
        if (invulneravel !== 1'b0) begin
            failures++;
            $display("FAIL window_end: inv=%b, want 0", invulneravel);
        end
        @(negedge clk);
        checks++;
        if (hex4 !== 7'h7F) begin
            failures++;
            $display("FAIL hex4_blank: hex4=%h, want 7f", hex4);
        end
    endtask

    task automatic test_pausa();
        @(negedge clk);
        pausa  = 1'b1;
        acerto = 1'b1;
        dano   = 1'b1;
        @(negedge clk);
        checks++;
        if (pontos !== 16'h0030 || vidas !== 4'd2) begin
            failures++;
            $display("FAIL pausa_events: pontos=%h vidas=%0d, want 0030 2", pontos, vidas);
        end
        pausa = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (pontos !== 16'h0030 || vidas !== 4'd2 || invulneravel !== 1'b0) begin
            failures++;
            $display("FAIL pausa_edge_lost: pontos=%h vidas=%0d inv=%b, want 0030 2 0",
                     pontos, vidas, invulneravel);
        end
        acerto = 1'b0;
        dano   = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pause_hold();
        pulse_dano();
        pausa = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (invulneravel !== 1'b1 || vidas !== 4'd1) begin
            failures++;
            $display("FAIL pause_hold: inv=%b vidas=%0d, want 1 1", invulneravel, vidas);
        end
        pausa = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (invulneravel !== 1'b1) begin
            failures++;
            $display("FAIL pause_hold_last: inv=%b, want 1", invulneravel);
        end
        @(negedge clk);
        checks++;
        if (invulneravel !== 1'b0) begin
            failures++;
            $display("FAIL pause_hold_end: inv=%b, want 0", invulneravel);
        end
    endtask

    task automatic test_simultaneous();
        @(negedge clk);
        acerto = 1'b1;
        dano   = 1'b1;
        @(negedge clk);
        checks++;
        if (pontos !== 16'h0040 || vidas !== 4'd0 || perdeu !== 1'b1) begin
            failures++;
            $display("FAIL simultaneous: pontos=%h vidas=%0d perdeu=%b, want 0040 0 1",
                     pontos, vidas, perdeu);
        end
        acerto = 1'b0;
        dano   = 1'b0;
        pulse_acerto();
        pulse_dano();
        checks++;
        if (pontos !== 16'h0040 || vidas !== 4'd0 || perdeu !== 1'b1) begin
            failures++;
            $display("FAIL fim_frozen: pontos=%h vidas=%0d perdeu=%b, want 0040 0 1",
                     pontos, vidas, perdeu);
        end
    endtask

    task automatic test_reset_async();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (perdeu !== 1'b0 || vidas !== 4'd3 || pontos !== 16'h0000 || invulneravel !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: perdeu=%b vidas=%0d pontos=%h inv=%b, want 0 3 0000 0",
                     perdeu, vidas, pontos, invulneravel);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_game_over();
        pulse_dano();
        repeat (12) @(negedge clk);
        pulse_dano();
        repeat (12) @(negedge clk);
        checks++;
        if (vidas !== 4'd1 || perdeu !== 1'b0) begin
            failures++;
            $display("FAIL two_hits: vidas=%0d perdeu=%b, want 1 0", vidas, perdeu);
        end
        pulse_dano();
        checks++;
        if (vidas !== 4'd0 || perdeu !== 1'b1 || invulneravel !== 1'b0) begin
            failures++;
            $display("FAIL third_hit: vidas=%0d perdeu=%b inv=%b, want 0 1 0",
                     vidas, perdeu, invulneravel);
        end
        pulse_acerto();
        checks++;
        if (pontos !== 16'h0000 || hex5 !== 7'h40) begin
            failures++;
            $display("FAIL fim_acerto: pontos=%h hex5=%h, want 0000 40", pontos, hex5);
        end
        test_reset_async();
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (999) pulse_acerto();
        checks++;
        if (pontos !== 16'h9990) begin
            failures++;
            $display("FAIL preload_9990: pontos=%h, want 9990", pontos);
        end
        @(negedge clk);
        checks++;
        if (hex3 !== 7'h10 || hex2 !== 7'h10 || hex1 !== 7'h10 || hex0 !== 7'h40) begin
            failures++;
            $display("FAIL hex_9990: hex3..0=%h %h %h %h, want 10 10 10 40",
                     hex3, hex2, hex1, hex0);
        end
        pulse_acerto();
        checks++;
        if (pontos !== 16'h9999) begin
            failures++;
            $display("FAIL saturate_10: pontos=%h, want 9999", pontos);
        end
        pulse_acerto();
        checks++;
        if (pontos !== 16'h9999) begin
            failures++;
            $display("FAIL saturate_hold: pontos=%h, want 9999", pontos);
        end
        repeat (1999) pulse_acerto2();
        checks++;
        if (pontos2 !== 16'h9995) begin
            failures++;
            $display("FAIL preload_9995: pontos=%h, want 9995", pontos2);
        end
        pulse_acerto2();
        checks++;
        if (pontos2 !== 16'h9999) begin
            failures++;
            $display("FAIL saturate_05: pontos=%h, want 9999", pontos2);
        end
    endtask

    initial begin
        test_reset();
        test_acerto();
        test_invuln();
        test_pausa();
        test_pause_hold();
        test_simultaneous();
        test_reset_async();
        test_game_over();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
